// File: rtl/ascii_to_ps2_seq.sv
// ascii_to_ps2_seq
// Turns one ASCII character into the PS/2 scan-code set 2 byte sequence that a
// US keyboard would send for that keystroke. The sequence is make, F0, make, and
// shifted characters are wrapped in a left-shift press/release (12 ... F0 12).
// Characters come in through a valid/ready sink. Scan-code bytes leave through a
// valid/ready source, one byte per handshake.
//
// Parameters:
//   GAP_CYCLES   idle cycles after each accepted output byte (0..255)
// Optional feature macro:
//   ASCII_TO_PS2_SHIFT_EN  when defined, shifted characters get the shift
//                          wrapper. When undefined, they are reported as unmapped.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   ascii_in/valid/ready        character input handshake (ready only in IDLE)
//   code_out/valid/ready        scan-code output handshake
//   busy                        high whenever not IDLE
//   err                         one-cycle pulse for an accepted unmapped character
module ascii_to_ps2_seq #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EMIT = 2'd1, ST_GAP = 2'd2} state_t;

  localparam logic [7:0] GAP_LOAD = GAP_CYCLES[7:0];

  // Make code of a lowercase letter, indexed from 'a'.
  function automatic logic [7:0] letter_make(input logic [7:0] i);
    case (i)
      8'd0:  letter_make = 8'h1C;  8'd1:  letter_make = 8'h32;  8'd2:  letter_make = 8'h21;
      8'd3:  letter_make = 8'h23;  8'd4:  letter_make = 8'h24;  8'd5:  letter_make = 8'h2B;
      8'd6:  letter_make = 8'h34;  8'd7:  letter_make = 8'h33;  8'd8:  letter_make = 8'h43;
      8'd9:  letter_make = 8'h3B;  8'd10: letter_make = 8'h42;  8'd11: letter_make = 8'h4B;
      8'd12: letter_make = 8'h3A;  8'd13: letter_make = 8'h31;  8'd14: letter_make = 8'h44;
      8'd15: letter_make = 8'h4D;  8'd16: letter_make = 8'h15;  8'd17: letter_make = 8'h2D;
      8'd18: letter_make = 8'h1B;  8'd19: letter_make = 8'h2C;  8'd20: letter_make = 8'h3C;
      8'd21: letter_make = 8'h2A;  8'd22: letter_make = 8'h1D;  8'd23: letter_make = 8'h22;
      8'd24: letter_make = 8'h35;  8'd25: letter_make = 8'h1A;
      default: letter_make = 8'h00;
    endcase
  endfunction

  // Lookup result is {mapped, shifted, make_code}.
  function automatic logic [9:0] lookup(input logic [7:0] ch);
    if ((ch >= 8'h61) && (ch <= 8'h7A)) begin
      lookup = {2'b10, letter_make(ch - 8'h61)};
    end else if ((ch >= 8'h41) && (ch <= 8'h5A)) begin
      lookup = {2'b11, letter_make(ch - 8'h41)};
    end else begin
      case (ch)
        8'h30: lookup = {2'b10, 8'h45};  8'h31: lookup = {2'b10, 8'h16};
        8'h32: lookup = {2'b10, 8'h1E};  8'h33: lookup = {2'b10, 8'h26};
        8'h34: lookup = {2'b10, 8'h25};  8'h35: lookup = {2'b10, 8'h2E};
        8'h36: lookup = {2'b10, 8'h36};  8'h37: lookup = {2'b10, 8'h3D};
        8'h38: lookup = {2'b10, 8'h3E};  8'h39: lookup = {2'b10, 8'h46};
        8'h29: lookup = {2'b11, 8'h45};  8'h21: lookup = {2'b11, 8'h16};
        8'h40: lookup = {2'b11, 8'h1E};  8'h23: lookup = {2'b11, 8'h26};
        8'h24: lookup = {2'b11, 8'h25};  8'h25: lookup = {2'b11, 8'h2E};
        8'h5E: lookup = {2'b11, 8'h36};  8'h26: lookup = {2'b11, 8'h3D};
        8'h2A: lookup = {2'b11, 8'h3E};  8'h28: lookup = {2'b11, 8'h46};
        8'h60: lookup = {2'b10, 8'h0E};  8'h2D: lookup = {2'b10, 8'h4E};
        8'h3D: lookup = {2'b10, 8'h55};  8'h5B: lookup = {2'b10, 8'h54};
        8'h5D: lookup = {2'b10, 8'h5B};  8'h5C: lookup = {2'b10, 8'h5D};
        8'h3B: lookup = {2'b10, 8'h4C};  8'h27: lookup = {2'b10, 8'h52};
        8'h2C: lookup = {2'b10, 8'h41};  8'h2E: lookup = {2'b10, 8'h49};
        8'h2F: lookup = {2'b10, 8'h4A};
        8'h7E: lookup = {2'b11, 8'h0E};  8'h5F: lookup = {2'b11, 8'h4E};
        8'h2B: lookup = {2'b11, 8'h55};  8'h7B: lookup = {2'b11, 8'h54};
        8'h7D: lookup = {2'b11, 8'h5B};  8'h7C: lookup = {2'b11, 8'h5D};
        8'h3A: lookup = {2'b11, 8'h4C};  8'h22: lookup = {2'b11, 8'h52};
        8'h3C: lookup = {2'b11, 8'h41};  8'h3E: lookup = {2'b11, 8'h49};
        8'h3F: lookup = {2'b11, 8'h4A};
        8'h20: lookup = {2'b10, 8'h29};  8'h0A: lookup = {2'b10, 8'h5A};
        8'h08: lookup = {2'b10, 8'h66};
        default: lookup = 10'h000;
      endcase
    end
  endfunction

  // Byte number idx of the make/break sequence.
  function automatic logic [7:0] seq_byte(input logic [2:0] idx, input logic [7:0] make,
                                          input logic shift);
    if (shift) begin
      case (idx)
        3'd0: seq_byte = 8'h12;  3'd1: seq_byte = make;  3'd2: seq_byte = 8'hF0;
        3'd3: seq_byte = make;   3'd4: seq_byte = 8'hF0; 3'd5: seq_byte = 8'h12;
        default: seq_byte = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0: seq_byte = make;  3'd1: seq_byte = 8'hF0;  3'd2: seq_byte = make;
        default: seq_byte = 8'h00;
      endcase
    end
  endfunction

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] make_q, make_d;
  logic       shift_q, shift_d;
  logic       err_q, err_d;
  logic       ascii_ready_q, ascii_ready_d;
  logic       busy_q, busy_d;
  logic       code_valid_q, code_valid_d;
  logic [7:0] code_out_q, code_out_d;
  logic [9:0] lk_s;
  logic       hit_s, shf_s;
  logic [2:0] seq_len_s;

  assign lk_s = lookup(ascii_in);
`ifdef ASCII_TO_PS2_SHIFT_EN
  assign hit_s = lk_s[9];
  assign shf_s = lk_s[8];
`else
  // Without the shift wrapper a shifted character cannot be expressed.
  assign hit_s = lk_s[9] & ~lk_s[8];
  assign shf_s = 1'b0;
`endif
  assign seq_len_s = shift_q ? 3'd6 : 3'd3;

  // Next-state, sequence index, gap counter and registered-output computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    make_d  = make_q;
    shift_d = shift_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ascii_valid && ascii_ready_q) begin
          make_d  = lk_s[7:0];
          shift_d = shf_s;
          idx_d   = 3'd0;
          gap_d   = 8'd0;
          if (hit_s) begin
            state_d = ST_EMIT;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (code_ready) begin
          // idx runs one past the last byte so a trailing gap knows to finish.
          idx_d = idx_q + 3'd1;
          if (GAP_LOAD != 8'd0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else if (idx_d == seq_len_s) begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_GAP: begin
        if (gap_q <= 8'd1) begin
          gap_d = 8'd0;
          if (idx_q == seq_len_s) begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_EMIT;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
        gap_d   = 8'd0;
      end
    endcase
    ascii_ready_d = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    code_valid_d  = (state_d == ST_EMIT);
    if (code_valid_d) begin
      code_out_d = seq_byte(idx_d, make_d, shift_d);
    end else begin
      code_out_d = 8'h00;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= 3'd0;
      gap_q         <= 8'd0;
      make_q        <= 8'h00;
      shift_q       <= 1'b0;
      err_q         <= 1'b0;
      ascii_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      code_valid_q  <= 1'b0;
      code_out_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      make_q        <= make_d;
      shift_q       <= shift_d;
      err_q         <= err_d;
      ascii_ready_q <= ascii_ready_d;
      busy_q        <= busy_d;
      code_valid_q  <= code_valid_d;
      code_out_q    <= code_out_d;
    end
  end

  assign ascii_ready = ascii_ready_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign code_valid  = code_valid_q;
  assign code_out    = code_out_q;

endmodule

// File: doc/ascii_to_ps2_seq.md
# ascii_to_ps2_seq

Converts one ASCII character into the PS/2 scan-code set 2 byte sequence that a US keyboard would send for that keystroke, including make, break and shift wrapping. It sits on the messenger's loopback/replay path. Stored or received characters are fed in and re-injected as scan-code bytes into the PS/2-side decode chain, so the keyboard path can be exercised without a physical keyboard. The input side is a byte-wide valid/ready sink; the output side is a byte-wide valid/ready source, one scan-code byte per handshake.

## Interface
- GAP_CYCLES, 0, idle cycles inserted after each accepted output byte before the next byte is presented (0..255).
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- ascii_in  input  8  character to encode; sampled on input handshake.
- ascii_valid  input  1  ascii_in valid.
- ascii_ready  output  1  block can accept a character (high only in IDLE).
- code_out  output  8  current scan-code byte.
- code_valid  output  1  code_out valid.
- code_ready  input  1  downstream accepts code_out.
- busy  output  1  high in any state except IDLE.
- err  output  1  one-cycle pulse: accepted character has no mapping.

## Operation
- Mapping (set 2, US layout):
  - Lowercase a–z: unshifted letter make code.
  - Uppercase A–Z: the same make code, shifted.
  - Digits 0–9: 45,16,1E,26,25,2E,36,3D,3E,46, unshifted.
  - Shifted digit-row symbols: ) ! @ # $ % ^ & * ( use the same codes.
  - Punctuation row `-=[]\;',./ uses 0E 4E 55 54 5B 5D 4C 52 41 49 4A unshifted.
  - Their shifted counterparts ~_+{}|:"<>? use the same codes, shifted.
  - Space 0x20 → 29, LF 0x0A → 5A, BS 0x08 → 66, all unshifted.
  - Every other value is unmapped.
- Sequences:
  - Unshifted: make, F0, make (3 bytes).
  - Shifted: 12, make, F0, make, F0, 12 (6 bytes).
- FSM states: IDLE, EMIT, GAP.
- IDLE:
  - ascii_ready=1.
  - On ascii_valid&ascii_ready, look up ascii_in combinationally and register the make code, the shift flag and sequence length; set idx=0.
  - Mapped character → EMIT. Unmapped → err=1 next cycle, stay IDLE.
- EMIT:
  - code_valid=1; code_out = sequence byte idx.
  - On code_ready: if idx is the last byte → IDLE; else idx+1, then → GAP if GAP_CYCLES>0, otherwise stay in EMIT.
- GAP:
  - code_valid=0.
  - Down-counter loaded with GAP_CYCLES on entry; → EMIT when it reaches 1.
  - A gap also follows the last byte before IDLE when GAP_CYCLES>0.
- ascii_valid is ignored while busy. Only one character is in flight; there is no input buffer.
- code_out is held stable while code_valid=1 and code_ready=0 (backpressure indefinitely).

## Timing
- Reset values:
  - State IDLE; ascii_ready=1, busy=0, err=0.
  - code_valid=0, code_out=8'h00; idx=0, gap counter=0.
- Reset mid-sequence: the next cycle is IDLE with outputs at reset values. The remaining bytes are dropped and the character is not resumed.
- Latency: input handshake at edge N → code_valid=1 with the first byte from cycle N+1.
- GAP_CYCLES=0: a byte is accepted every cycle while code_ready=1. An unshifted character occupies 3 cycles, a shifted one 6.
- GAP_CYCLES=G: exactly G cycles with code_valid=0 after each byte handshake.
- Return to IDLE: ascii_ready rises the cycle after the final byte handshake (or after the final gap). It is never high in the same cycle as code_valid.
- err: asserted in cycle N+1 for an unmapped accept at edge N, for exactly one cycle. ascii_ready remains 1, so back-to-back accepts are allowed.

## Configuration
- ASCII_TO_PS2_SHIFT_EN defined:
  - Shifted characters are encoded with the 12 make / F0 12 break wrapper (6-byte sequence).
- ASCII_TO_PS2_SHIFT_EN undefined:
  - All shifted characters (uppercase letters, shifted symbols) are treated as unmapped: err pulse, no bytes emitted.
  - Sequence length is always 3; idx width may shrink to 2 bits.

## Test plan
- Send 0x61 ('a') with GAP_CYCLES=0, code_ready=1 → bytes 1C, F0, 1C on three consecutive cycles starting N+1; ascii_ready back at 1 after the third byte; err stays 0.
- Send 0x41 ('A') with ASCII_TO_PS2_SHIFT_EN defined → 12, 1C, F0, 1C, F0, 12. Without the macro → err pulse at N+1, code_valid never asserted.
- Send 0x21 ('!') with code_ready toggling 1,0,0,1,… → 12, 16, F0, 16, F0, 12, each byte held stable through stalls; ascii_valid pulses during busy are ignored.
- Send 0x7F, then immediately 0x20 → err high for one cycle, no bytes for 0x7F; then 29, F0, 29.
- GAP_CYCLES=2, send 0x0A → 5A, 2 idle cycles, F0, 2 idle cycles, 5A, 2 idle cycles, then ascii_ready=1.
- Send 0x5A ('Z', shifted) and assert reset after the second byte → next cycle IDLE, code_valid=0, code_out=00, ascii_ready=1; a following 0x08 gives 66, F0, 66.
